mem_arbiter: RTL and testbench

Two-port arbiter that shares the single 256x8 program/data memory of the RISC SPM between the CPU memory interface (port 0) and a program-loader/debug master (port 1). The block accepts one request at a time and drives a registered single-port synchronous memory interface. It returns read data to the winning requester at a fixed cadence of one access every two cycles. Memory sits directly behind this block; the CPU control unit's address register and write strobe feed port 0.

---
 rtl/risc_spm_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/rr_arb2.sv | 25 ++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC SPM memory subsystem: bus width defaults,
// the memory arbiter state encoding and requester port indices.
package risc_spm_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Arbiter FSM: ACC is the cycle the memory samples the access, RSP is the
  // cycle read data comes back and the next winner is chosen.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// slave: the arbiter itself. master: the requesters plus the memory.
interface mem_arbiter_if
  import risc_spm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way picker. A lone request wins outright; on a tie the
// port that did not win last time wins when rr_en is set, else port 0 wins.
module rr_arb2
  import risc_spm_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       win,
  output logic       win_vld
);

  // winner selection
  always_comb begin
    win_vld = |req;
    win     = PORT_CPU;
    case (req)
      2'b01:   win = PORT_CPU;
      2'b10:   win = PORT_LDR;
      2'b11:   win = rr_en ? ~last : PORT_CPU;
      default: win = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port 256x8 SPM memory. Port 0 is
// the CPU, port 1 the loader/debug master. One access every two cycles:
// ACC (memory samples registered outputs) then RSP (read data returned and
// the next winner loaded straight into the memory registers).
module mem_arbiter
  import risc_spm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RR     = 1
)(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e state_q, state_d;

  logic              cur;      // port owning the access in flight
  logic              last;     // most recent winner, for round-robin ties
  logic              cur_we;   // in-flight access is a write (no rvalid)
  logic              load;     // capture the winner into the memory regs

  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [1:0]              req_v;
  logic [1:0]              we_v;
  logic [1:0][ADDR_W-1:0]  addr_v;
  logic [1:0][DATA_W-1:0]  wdata_v;
  logic [1:0]              gnt_v, rvalid_v;

  logic win, win_vld;

  assign req_v   = {bus.req1,   bus.req0};
  assign we_v    = {bus.we1,    bus.we0};
  assign addr_v  = {bus.addr1,  bus.addr0};
  assign wdata_v = {bus.wdata1, bus.wdata0};

  rr_arb2 u_arb (
    .req     (req_v),
    .last    (last),
    .rr_en   (RR != 0),
    .win     (win),
    .win_vld (win_vld)
  );

  // next state; IDLE and RSP arbitrate identically
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          load    = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_ACC:  state_d = ST_RSP;
      ST_RSP: begin
        if (win_vld) begin
          load    = 1'b1;
          state_d = ST_ACC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // winner bookkeeping and registered memory interface; addr/wdata hold
  // their value between accesses, only the strobes drop
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= PORT_CPU;
      last        <= PORT_LDR;
      cur_we      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (load) begin
      cur         <= win;
      last        <= win;
      cur_we      <= we_v[win];
      mem_en_q    <= 1'b1;
      mem_we_q    <= we_v[win];
      mem_addr_q  <= addr_v[win];
      mem_wdata_q <= wdata_v[win];
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end
  end

  // response demux: gnt in ACC, rvalid in RSP for reads only
  for (genvar p = 0; p < 2; p++) begin : g_rsp
    assign gnt_v[p]    = (state_q == ST_ACC) && (cur == p[0]);
    assign rvalid_v[p] = (state_q == ST_RSP) && (cur == p[0]) && !cur_we;
  end

  assign bus.gnt0      = gnt_v[0];
  assign bus.gnt1      = gnt_v[1];
  assign bus.rvalid0   = rvalid_v[0];
  assign bus.rvalid1   = rvalid_v[1];
  assign bus.rdata0    = bus.mem_rdata;
  assign bus.rdata1    = bus.mem_rdata;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance, each
// with its own memory model. sel chooses which one the requesters talk to.
// The monitor predicts every cycle from the arbitration rules and a
// reference memory, queuing expected read data at grant time.
module tb_mem_arbiter;
  import risc_spm_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  logic sel = 1'b1;   // 1: RR instance active, 0: fixed-priority instance
  always #5 clk = ~clk;

  logic [1:0]          drv_req = '0;
  logic [1:0]          drv_we = '0;
  logic [1:0][AW-1:0]  drv_addr = '0;
  logic [1:0][DW-1:0]  drv_wdata = '0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifr ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifp ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1)) u_rr (.clk(clk), .rst(rst), .bus(ifr));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0)) u_fp (.clk(clk), .rst(rst), .bus(ifp));

  assign ifr.req0 = sel & drv_req[0];
  assign ifr.req1 = sel & drv_req[1];
  assign ifp.req0 = !sel & drv_req[0];
  assign ifp.req1 = !sel & drv_req[1];
  assign ifr.we0 = drv_we[0];      assign ifr.we1 = drv_we[1];
  assign ifp.we0 = drv_we[0];      assign ifp.we1 = drv_we[1];
  assign ifr.addr0 = drv_addr[0];  assign ifr.addr1 = drv_addr[1];
  assign ifp.addr0 = drv_addr[0];  assign ifp.addr1 = drv_addr[1];
  assign ifr.wdata0 = drv_wdata[0]; assign ifr.wdata1 = drv_wdata[1];
  assign ifp.wdata0 = drv_wdata[0]; assign ifp.wdata1 = drv_wdata[1];

  function automatic logic [7:0] init_val(input int i);
    return (i == 16) ? 8'hA5 : 8'(i * 37 + 11);
  endfunction

  // synchronous memories behind each arbiter
  logic [7:0] mem_r [256];
  logic [7:0] mem_f [256];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        mem_r[i] <= init_val(i);
        mem_f[i] <= init_val(i);
      end
    end else begin
      if (ifr.mem_en) begin
        if (ifr.mem_we) mem_r[ifr.mem_addr] <= ifr.mem_wdata;
        else            ifr.mem_rdata <= mem_r[ifr.mem_addr];
      end
      if (ifp.mem_en) begin
        if (ifp.mem_we) mem_f[ifp.mem_addr] <= ifp.mem_wdata;
        else            ifp.mem_rdata <= mem_f[ifp.mem_addr];
      end
    end
  end

  // active-instance view
  logic [1:0]         m_gnt, m_rv, m_req;
  logic [1:0][DW-1:0] m_rdata;
  logic               m_en, m_we, m_busy;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  assign m_gnt   = sel ? {ifr.gnt1, ifr.gnt0} : {ifp.gnt1, ifp.gnt0};
  assign m_rv    = sel ? {ifr.rvalid1, ifr.rvalid0} : {ifp.rvalid1, ifp.rvalid0};
  assign m_req   = sel ? {ifr.req1, ifr.req0} : {ifp.req1, ifp.req0};
  assign m_rdata = sel ? {ifr.rdata1, ifr.rdata0} : {ifp.rdata1, ifp.rdata0};
  assign m_en    = sel ? ifr.mem_en : ifp.mem_en;
  assign m_we    = sel ? ifr.mem_we : ifp.mem_we;
  assign m_busy  = sel ? ifr.busy : ifp.busy;
  assign m_addr  = sel ? ifr.mem_addr : ifp.mem_addr;
  assign m_wdata = sel ? ifr.mem_wdata : ifp.mem_wdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model and monitor
  logic [7:0] ref_mem [2][256];
  initial begin
    logic       r_prev, p_acc, p_win, p_we, last_m, exp_acc, w;
    logic [1:0] p_req, exp_g, exp_rv;
    logic [7:0] p_rd, rd;
    int         s;
    r_prev = 1; p_acc = 0; p_win = 0; p_we = 0; last_m = 1; p_req = 0; p_rd = 0;
    forever begin
      @(negedge clk);
      if (preload) begin
        for (int i = 0; i < 256; i++) begin
          ref_mem[0][i] = init_val(i);
          ref_mem[1][i] = init_val(i);
        end
        r_prev = 1; p_acc = 0; p_req = 0; last_m = 1;
      end else begin
        s  = sel ? 1 : 0;
        rd = 8'h00;
        if (r_prev) last_m = 1;
        // an access starts whenever a request was seen outside ACC and no reset hit
        exp_acc = !r_prev && (p_req != 2'b00) && !p_acc;
        if (p_req == 2'b10)                w = 1'b1;
        else if (p_req == 2'b11 && sel)    w = !last_m;
        else                               w = 1'b0;
        exp_g = exp_acc ? (w ? 2'b10 : 2'b01) : 2'b00;
        chk("gnt", 32'(m_gnt), 32'(exp_g));
        chk("mem_en", 32'(m_en), 32'(exp_acc));
        chk("mem_we", 32'(m_we), 32'(exp_acc & drv_we[w]));
        if (exp_acc) begin
          chk("mem_addr", 32'(m_addr), 32'(drv_addr[w]));
          chk("mem_wdata", 32'(m_wdata), 32'(drv_wdata[w]));
          if (drv_we[w]) ref_mem[s][drv_addr[w]] = drv_wdata[w];
          else           rd = ref_mem[s][drv_addr[w]];
          last_m = w;
        end
        if (r_prev) begin
          chk("rst_mem_addr", 32'(m_addr), 32'h0);
          chk("rst_mem_wdata", 32'(m_wdata), 32'h0);
        end
        exp_rv = (!r_prev && p_acc && !p_we) ? (p_win ? 2'b10 : 2'b01) : 2'b00;
        chk("rvalid", 32'(m_rv), 32'(exp_rv));
        if (exp_rv[0]) chk("rdata0", 32'(m_rdata[0]), 32'(p_rd));
        if (exp_rv[1]) chk("rdata1", 32'(m_rdata[1]), 32'(p_rd));
        chk("busy", 32'(m_busy), 32'(!r_prev && (exp_acc || p_acc)));
        p_acc = exp_acc; p_win = w; p_we = drv_we[w]; p_rd = rd;
        p_req = m_req; r_prev = rst;
      end
    end
  end

  // present one payload and hold it until the grant is seen
  task automatic do_txn(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    int t;
    drv_we[p] = we; drv_addr[p] = a; drv_wdata[p] = d; drv_req[p] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_gnt[p] && t < 64);
    if (!m_gnt[p]) begin
      $display("FAIL gnt_timeout port %0d: gnt=0 after 64 cycles, expected 1", p);
      $fatal(1, "aborting");
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_port(input int p, input int n, input int gapmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gapmax, 0)) begin
        drv_req[p] = 1'b0;
        @(posedge clk); #1;
      end
      do_txn(p, 1'($urandom_range(1, 0)), 8'h40 | 8'($urandom_range(15, 0)), 8'($urandom));
    end
    drv_req[p] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // two reset edges, memories preloaded meanwhile
    @(posedge clk); #1;
    @(posedge clk); #1;
    preload = 0; rst = 0;
    idle(2);
    // read of preloaded 0xA5 at 0x10
    do_txn(0, 1'b0, 8'h10, 8'h00); drv_req[0] = 0;
    idle(2);
    // port 1 write then back-to-back read of the same address
    do_txn(1, 1'b1, 8'h80, 8'h3C);
    do_txn(1, 1'b0, 8'h80, 8'h00); drv_req[1] = 0;
    idle(2);
    // continuous contention, round-robin
    fork
      begin for (int i = 0; i < 4; i++) do_txn(0, 1'b0, 8'(8'h20 + i), 8'h00); drv_req[0] = 0; end
      begin for (int i = 0; i < 4; i++) do_txn(1, 1'b1, 8'(8'h40 + i), 8'(8'hC0 + i)); drv_req[1] = 0; end
    join
    idle(2);
    fork
      rand_port(0, 30, 3);
      rand_port(1, 30, 3);
    join
    idle(3);
    // fixed-priority instance: port 1 starves until port 0 stops
    sel = 0;
    idle(1);
    fork
      begin for (int i = 0; i < 4; i++) do_txn(0, 1'b0, 8'(8'h10 + i), 8'h00); drv_req[0] = 0; end
      begin do_txn(1, 1'b0, 8'h80, 8'h00); drv_req[1] = 0; end
    join
    idle(2);
    fork
      rand_port(0, 20, 2);
      rand_port(1, 20, 2);
    join
    idle(3);
    // reset during the ACC of a read drops the response
    sel = 1;
    idle(1);
    drv_we[0] = 0; drv_addr[0] = 8'h22; drv_req[0] = 1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; drv_req[0] = 0;
    idle(3);
    do_txn(0, 1'b0, 8'h10, 8'h00); drv_req[0] = 0;
    do_txn(1, 1'b0, 8'h80, 8'h00); drv_req[1] = 0;
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "aborting");
  end

endmodule
